// File: rtl/grad_ctrl_pkg.sv
// Shared state encodings and pump drive codes for the gradient generator run sequencer.
package grad_ctrl_pkg;

  typedef logic [2:0] grad_state_t;

  localparam grad_state_t StIdle    = 3'd0;
  localparam grad_state_t StPrime   = 3'd1;
  localparam grad_state_t StSettle  = 3'd2;
  localparam grad_state_t StCollect = 3'd3;
  localparam grad_state_t StWaitAck = 3'd4;
  localparam grad_state_t StFlush   = 3'd5;
  localparam grad_state_t StDone    = 3'd6;

  // bit0 = soln1 pump, bit1 = soln2 pump
  localparam logic [1:0] PUMP_OFF  = 2'b00;
  localparam logic [1:0] PUMP_S1   = 2'b01;
  localparam logic [1:0] PUMP_BOTH = 2'b11;

endpackage

// File: rtl/grad_dwell_timer.sv
// Dwell counter: loads a cycle count on state entry, counts down, flags expiry at zero.
module grad_dwell_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/grad_gen_seq.sv
// Run sequencer for the two-inlet gradient generator: prime, settle, per-outlet collect/handoff.
// Optional post-run soln1 flush is enabled by defining GRAD_FLUSH_EN.
module grad_gen_seq
  import grad_ctrl_pkg::*;
#(
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned PRIME_CYC   = 16,
  parameter int unsigned SETTLE_CYC  = 64,
  parameter int unsigned COLLECT_CYC = 8,
  parameter int unsigned FLUSH_CYC   = 32,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       sample_ack,
  output logic [1:0]                 pump_en,
  output logic [NUM_OUT-1:0]         out_valve,
  output logic [$clog2(NUM_OUT)-1:0] chan_idx,
  output logic                       sample_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted
);

  localparam int unsigned ChanW = $clog2(NUM_OUT);
  localparam logic [ChanW-1:0] LastChan = ChanW'(NUM_OUT - 1);

  grad_state_t      state_q, state_d;
  logic [ChanW-1:0] chan_q, chan_d;
  logic             aborted_d;

  logic             dwell_load;
  logic [CNT_W-1:0] dwell_val;
  logic             dwell_expire;

  logic [1:0]         pump_d;
  logic [NUM_OUT-1:0] valve_d;
  logic               valid_d, busy_d, done_d;

  grad_dwell_timer #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (dwell_load),
    .load_val (dwell_val),
    .expire   (dwell_expire)
  );

  // Abort outranks ack and dwell expiry, so it is resolved before the state decode.
  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    aborted_d = 1'b0;
    if (state_q != StIdle && abort) begin
      state_d   = StIdle;
      chan_d    = '0;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        StIdle:    if (start) state_d = StPrime;
        StPrime:   if (dwell_expire) state_d = StSettle;
        StSettle:  if (dwell_expire) state_d = StCollect;
        StCollect: if (dwell_expire) state_d = StWaitAck;
        StWaitAck: begin
          if (sample_ack) begin
            if (chan_q == LastChan) begin
`ifdef GRAD_FLUSH_EN
              state_d = StFlush;
`else
              state_d = StDone;
`endif
            end else begin
              chan_d  = chan_q + ChanW'(1);
              state_d = StCollect;
            end
          end
        end
`ifdef GRAD_FLUSH_EN
        StFlush:   if (dwell_expire) state_d = StDone;
`endif
        StDone: begin
          state_d = StIdle;
          chan_d  = '0;
        end
        default: begin
          state_d = StIdle;
          chan_d  = '0;
        end
      endcase
    end
  end

  // Every transition is a state change, so entry is detected as a change of state.
  always_comb begin
    dwell_load = (state_d != state_q);
    case (state_d)
      StPrime:   dwell_val = CNT_W'(PRIME_CYC - 1);
      StSettle:  dwell_val = CNT_W'(SETTLE_CYC - 1);
      StCollect: dwell_val = CNT_W'(COLLECT_CYC - 1);
`ifdef GRAD_FLUSH_EN
      StFlush:   dwell_val = CNT_W'(FLUSH_CYC - 1);
`endif
      default:   dwell_val = '0;
    endcase
  end

`ifndef GRAD_FLUSH_EN
  logic unused_flush_cyc;
  assign unused_flush_cyc = (FLUSH_CYC == 0);
`endif

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    pump_d  = PUMP_OFF;
    valve_d = '0;
    valid_d = 1'b0;
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
    case (state_d)
      StPrime, StSettle: begin
        pump_d  = PUMP_BOTH;
        valve_d = '1;
      end
      StCollect: begin
        pump_d  = PUMP_BOTH;
        valve_d = NUM_OUT'(1) << chan_d;
      end
      StWaitAck: valid_d = 1'b1;
`ifdef GRAD_FLUSH_EN
      StFlush: begin
        pump_d  = PUMP_S1;
        valve_d = '1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      chan_q       <= '0;
      pump_en      <= PUMP_OFF;
      out_valve    <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      pump_en      <= pump_d;
      out_valve    <= valve_d;
      sample_valid <= valid_d;
      busy         <= busy_d;
      done         <= done_d;
      aborted      <= aborted_d;
    end
  end

  assign chan_idx = chan_q;

endmodule

// File: doc/grad_gen_seq.md
Name: grad_gen_seq

Overview:
- Run sequencer for the two-inlet gradient generator (soln1/soln2 in, NUM_OUT graded outlet serpentines).
- Drives the inlet pump enables and the per-outlet valves.
- Steps through prime, settle and per-channel collection phases.
- Hands each collected outlet to the downstream sampler through a valid/ack handshake.
- Sits between the host control register block and the fluidic actuator drivers.

Parameters:
- NUM_OUT, 4, number of graded outlet channels (min 2).
- PRIME_CYC, 16, cycles both pumps run with all outlets open (min 1).
- SETTLE_CYC, 64, cycles for the gradient to stabilise, pumps on, outlets open (min 1).
- COLLECT_CYC, 8, cycles a single outlet is open for collection (min 1).
- FLUSH_CYC, 32, flush duration; used only with GRAD_FLUSH_EN (min 1).
- CNT_W, 16, dwell counter width; every *_CYC must be < 2**CNT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin run; sampled only in IDLE.
- abort  in  1  terminate run from any non-IDLE state.
- sample_ack  in  1  downstream has taken the current channel.
- pump_en  out  2  bit0 drives the soln1 pump, bit1 drives the soln2 pump.
- out_valve  out  NUM_OUT  outlet valve opens, one bit per channel.
- chan_idx  out  $clog2(NUM_OUT)  current collection channel.
- sample_valid  out  1  channel chan_idx ready for pickup.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort.

Behaviour:
- Reset: state IDLE. pump_en, out_valve, chan_idx, sample_valid, busy, done and aborted are all 0. Reset mid-run has the same effect, with no done or aborted pulse.
- All outputs are registered and decoded from the state and the counters.
- IDLE: all outputs 0. If start=1, the next state is PRIME and busy=1 from that cycle.
- PRIME: pump_en=2'b11, out_valve all 1s, for exactly PRIME_CYC cycles, then SETTLE.
- SETTLE: same outputs as PRIME, for exactly SETTLE_CYC cycles, then COLLECT.
- COLLECT: pump_en=2'b11, out_valve one-hot at chan_idx, for exactly COLLECT_CYC cycles, then WAIT_ACK.
- WAIT_ACK: pumps off, valves closed, sample_valid=1. The state holds until sample_ack=1.
  - Ack when chan_idx < NUM_OUT-1: chan_idx increments and the next state is COLLECT.
  - Ack when chan_idx = NUM_OUT-1: next state is DONE (FLUSH when GRAD_FLUSH_EN is defined).
- DONE: done=1 and busy=1 for one cycle, then IDLE with chan_idx cleared to 0.
- Dwell timing: the counter loads *_CYC-1 on state entry and decrements. The state exits in the cycle the counter reads 0.
- abort=1 in any non-IDLE state: next state is IDLE with all actuators off, aborted=1 for one cycle, and done is not asserted. abort has priority over sample_ack and over dwell expiry in the same cycle.
- start while not IDLE is ignored. sample_ack outside WAIT_ACK is ignored. abort in IDLE is ignored.

Optional Feature:
- Macro: GRAD_FLUSH_EN.
- Defined: after the final ack, a FLUSH state runs pump_en=2'b01 (soln1 only) with out_valve all 1s for FLUSH_CYC cycles, then DONE. abort during FLUSH behaves as in any other state.
- Undefined: the FLUSH state and the FLUSH_CYC logic are absent; the final ack goes directly to DONE.

Decomposition:
- Package grad_ctrl_pkg holds:
  - the state enum (IDLE, PRIME, SETTLE, COLLECT, WAIT_ACK, FLUSH, DONE);
  - the pump constants PUMP_OFF=2'b00, PUMP_S1=2'b01, PUMP_BOTH=2'b11.
- Sub-module grad_dwell_timer: load/decrement counter of width CNT_W with inputs load and load_val and output expire (count==0). Instantiated once in the sequencer.

Test Plan (NUM_OUT=4, PRIME_CYC=4, SETTLE_CYC=8, COLLECT_CYC=3, flush disabled):
- Nominal run: start at cycle T, ack each WAIT_ACK on its first cycle ->
  - busy from T+1;
  - pumps 11 with valves 1111 over T+1..T+12;
  - valve 0001 over T+13..T+15;
  - sample_valid at T+16, T+20, T+24, T+28;
  - done at T+29, IDLE at T+30.
- Delayed ack: hold sample_ack=0 for 10 cycles on channel 1 -> sample_valid stays 1 with chan_idx=1, pump_en=00 and out_valve=0000 throughout; resumes with 0100 after the ack.
- Abort during COLLECT of channel 2, asserted in the same cycle as dwell expiry -> next cycle IDLE, aborted=1, all outputs 0, no done, chan_idx=0.
- Spurious inputs: start pulsed during SETTLE and sample_ack pulsed during COLLECT -> timing identical to the nominal run.
- Synchronous reset asserted in WAIT_ACK -> all outputs 0 the next cycle, no pulses; a new start then gives the nominal timing.
- With GRAD_FLUSH_EN and FLUSH_CYC=5: after the final ack, pump_en=01 and valves 1111 for 5 cycles, then the done pulse.
